// File: rtl/div_pkg.sv
// div_pkg
// Shared definitions for the two-requester divider arbiter: the FSM state
// encoding and the default operand/result width.
package div_pkg;

    localparam int DIV_WIDTH = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/div_arbiter_if.sv
// div_arbiter_if
// Handshake and result bus between two requesters and the divider arbiter.
//   req0/req1 : requester N operands valid, held until ackN
//   a0/b0/a1/b1 : dividend/divisor of requester N (unsigned)
//   ack0/ack1 : one-cycle pulse, operands of requester N captured
//   busy      : operation in flight (capture until done)
//   done      : one-cycle pulse, quot/rem/dbz/done_id valid
//   done_id   : requester that owns the current result
//   quot/rem  : quotient/remainder, held until the next done
//   dbz       : divide-by-zero flag of the current result
// Modports: master = requester side, slave = arbiter side.
interface div_arbiter_if
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] a0;
    logic [WIDTH-1:0] b0;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             ack0;
    logic             ack1;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] quot;
    logic [WIDTH-1:0] rem;
    logic             dbz;

    modport master (
        output req0, req1, a0, b0, a1, b1,
        input  ack0, ack1, busy, done, done_id, quot, rem, dbz
    );

    modport slave (
        input  req0, req1, a0, b0, a1, b1,
        output ack0, ack1, busy, done, done_id, quot, rem, dbz
    );
endinterface

// File: rtl/div_arbiter_seq_div_core.sv
// seq_div_core
// Iterative unsigned restoring divider: one quotient bit per cycle, MSB
// first, WIDTH+1-bit partial remainder.
//   clk, rst  : clock, asynchronous active-low reset (control only)
//   start     : load dividend/divisor and begin WIDTH iterations
//   dividend, divisor : unsigned operands sampled on start
//   finished  : high during the cycle whose edge performs the last iteration
//   quot, rem : quotient/remainder, valid the cycle after finished
module seq_div_core
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             finished,
    output logic [WIDTH-1:0] quot,
    output logic [WIDTH-1:0] rem
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic [WIDTH:0]   prem;
    logic [WIDTH-1:0] qsr;
    logic [WIDTH-1:0] dsr;
    logic [CNT_W-1:0] cnt;
    logic             run;

    // One restoring step: shift the next dividend bit into the partial
    // remainder, subtract the divisor if it fits, shift the outcome into
    // the quotient register (which initially holds the dividend).
    function automatic logic [2*WIDTH:0] div_step(
        input logic [WIDTH:0]   p,
        input logic [WIDTH-1:0] q,
        input logic [WIDTH-1:0] d
    );
        logic [WIDTH+1:0] sh;
        logic [WIDTH+1:0] dext;
        logic [WIDTH:0]   pn;
        logic [WIDTH-1:0] qn;
        sh   = {p, q[WIDTH-1]};
        dext = {2'b00, d};
        if (sh >= dext) begin
            pn = (WIDTH+1)'(sh - dext);
            qn = {q[WIDTH-2:0], 1'b1};
        end else begin
            pn = sh[WIDTH:0];
            qn = {q[WIDTH-2:0], 1'b0};
        end
        return {pn, qn};
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (start) begin
            run <= 1'b1;
            cnt <= '0;
        end else if (run) begin
            cnt <= cnt + CNT_W'(1);
            if (finished) begin
                run <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (start) begin
            prem <= '0;
            qsr  <= dividend;
            dsr  <= divisor;
        end else if (run) begin
            {prem, qsr} <= div_step(prem, qsr, dsr);
        end
    end

    // Flagged one cycle early so the arbiter leaves CALC on the very edge
    // that produces the final quotient bit.
    assign finished = run && (cnt == CNT_W'(WIDTH - 1));
    assign quot     = qsr;
    assign rem      = prem[WIDTH-1:0];

endmodule

// File: rtl/div_arbiter.sv
// div_arbiter
// Round-robin arbiter in front of a shared iterative divider. Captures one
// requester's operands in IDLE, runs the division (or bypasses it for a
// zero divisor) and presents a registered result with its owner id.
//   clk  : clock, rising edge
//   rst  : asynchronous active-low reset
//   bus  : div_arbiter_if slave modport (requests, acks, results)
module div_arbiter
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    div_arbiter_if.slave bus
);

    state_t           state;
    state_t           state_n;
    logic             prio;       // requester that wins the next tie
    logic             gid;
    logic             capture;
    logic             core_start;
    logic             core_fin;
    logic             zero_div;
    logic             owner;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;
    logic [WIDTH-1:0] dvd_lat;
    logic [WIDTH-1:0] core_q;
    logic [WIDTH-1:0] core_r;

    logic             ack0_r;
    logic             ack1_r;
    logic             busy_r;
    logic             done_r;
    logic             done_id_r;
    logic             dbz_r;
    logic [WIDTH-1:0] quot_r;
    logic [WIDTH-1:0] rem_r;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        gid     = (bus.req0 && bus.req1) ? prio : bus.req1;
        sel_a   = gid ? bus.a1 : bus.a0;
        sel_b   = gid ? bus.b1 : bus.b0;
        state_n = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    capture = 1'b1;
                    state_n = (sel_b == '0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (core_fin) begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign core_start = capture && (sel_b != '0);

    seq_div_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .clk      (clk),
        .rst      (rst),
        .start    (core_start),
        .dividend (sel_a),
        .divisor  (sel_b),
        .finished (core_fin),
        .quot     (core_q),
        .rem      (core_r)
    );

    // Results are registered on the edge leaving DONE, so done lands
    // WIDTH+1 cycles after capture (1 cycle for the zero-divisor bypass).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prio      <= 1'b0;
            owner     <= 1'b0;
            zero_div  <= 1'b0;
            ack0_r    <= 1'b0;
            ack1_r    <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            done_id_r <= 1'b0;
            dbz_r     <= 1'b0;
            quot_r    <= '0;
            rem_r     <= '0;
        end else begin
            ack0_r <= capture && !gid;
            ack1_r <= capture && gid;
            done_r <= (state == DONE);
            if (capture) begin
                owner    <= gid;
                zero_div <= (sel_b == '0);
                prio     <= ~gid;
                busy_r   <= 1'b1;
            end
            if (state == DONE) begin
                busy_r    <= 1'b0;
                done_id_r <= owner;
                dbz_r     <= zero_div;
                quot_r    <= zero_div ? '1 : core_q;
                rem_r     <= zero_div ? dvd_lat : core_r;
            end
        end
    end

    // Dividend copy for the zero-divisor bypass, where the core never runs.
    always_ff @(posedge clk) begin
        if (capture) begin
            dvd_lat <= sel_a;
        end
    end

    assign bus.ack0    = ack0_r;
    assign bus.ack1    = ack1_r;
    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.done_id = done_id_r;
    assign bus.dbz     = dbz_r;
    assign bus.quot    = quot_r;
    assign bus.rem     = rem_r;

endmodule

// File: tb/tb_div_arbiter.sv
// tb_div_arbiter
// Directed bench for div_arbiter (WIDTH=64). Drivers issue requests and push
// the hand-computed result into a scoreboard; a monitor pops and compares
// whenever done pulses.
module tb_div_arbiter;
    import div_pkg::*;

    localparam int W = 64;
    localparam logic [W-1:0] ONES = '1;

    typedef struct {
        logic         id;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         z;
        int           due;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;
    int   ack_cyc [2];
    int   c0;
    exp_t sb [$];

    div_arbiter_if #(.WIDTH(W)) bus ();

    div_arbiter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        $display("FAIL %s: event did not occur as required", name);
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        exp_t e;
        if (rst && bus.done) begin
            if (sb.size() == 0) begin
                fail_now("unexpected_done");
            end else begin
                e = sb.pop_front();
                chk("done_id", W'(bus.done_id), W'(e.id));
                chk("quot", bus.quot, e.q);
                chk("rem", bus.rem, e.r);
                chk("dbz", W'(bus.dbz), W'(e.z));
                chk("done_cycle", W'(cyc), W'(e.due));
                chk("busy_at_done", W'(bus.busy), W'(0));
            end
        end
    end

    task automatic issue(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] q, input logic [W-1:0] r, input logic z);
        logic got = 1'b0;
        exp_t e;
        if (id) begin bus.a1 = a; bus.b1 = b; bus.req1 = 1'b1; end
        else    begin bus.a0 = a; bus.b0 = b; bus.req0 = 1'b1; end
        for (int t = 0; t < 300 && !got; t++) begin
            @(posedge clk); #1;
            got = id ? bus.ack1 : bus.ack0;
        end
        if (!got) begin
            fail_now(id ? "ack1_timeout" : "ack0_timeout");
        end else begin
            ack_cyc[id] = cyc;
            chk("busy_on_ack", W'(bus.busy), W'(1));
            e.id = id; e.q = q; e.r = r; e.z = z;
            e.due = cyc + (z ? 1 : W + 1);
            sb.push_back(e);
        end
        // Drop the request and scramble operands: must not affect the result.
        if (id) begin bus.req1 = 1'b0; bus.a1 = {$urandom, $urandom}; bus.b1 = {$urandom, $urandom}; end
        else    begin bus.req0 = 1'b0; bus.a0 = {$urandom, $urandom}; bus.b0 = {$urandom, $urandom}; end
    endtask

    task automatic wait_idle();
        logic ok = 1'b0;
        for (int t = 0; t < 400 && !ok; t++) begin
            @(posedge clk); #1;
            ok = (sb.size() == 0) && !bus.busy;
        end
        if (!ok) fail_now("idle_timeout");
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic tie(input logic [W-1:0] a0, b0, q0, r0, input logic [W-1:0] a1, b1, q1, r1,
                       input string name);
        fork
            issue(1'b0, a0, b0, q0, r0, 1'b0);
            issue(1'b1, a1, b1, q1, r1, 1'b0);
        join
        chk(name, W'(ack_cyc[1] - ack_cyc[0]), W'(W + 2));
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack0"}, W'(bus.ack0), W'(0));
        chk({tag, "_ack1"}, W'(bus.ack1), W'(0));
        chk({tag, "_busy"}, W'(bus.busy), W'(0));
        chk({tag, "_done"}, W'(bus.done), W'(0));
        chk({tag, "_done_id"}, W'(bus.done_id), W'(0));
        chk({tag, "_dbz"}, W'(bus.dbz), W'(0));
        chk({tag, "_quot"}, bus.quot, W'(0));
        chk({tag, "_rem"}, bus.rem, W'(0));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        bus.a0 = '0; bus.b0 = '0; bus.a1 = '0; bus.b1 = '0;
        rst = 1'b1;
        #1 rst = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        @(posedge clk); #1;

        // Single request, 100/7
        c0 = cyc;
        issue(1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 1'b0);
        chk("ack0_latency", W'(ack_cyc[0] - c0), W'(1));
        wait_idle();

        // Zero divisor bypass on requester 1
        issue(1'b1, 64'd5, 64'd0, ONES, 64'd5, 1'b1);
        wait_idle();

        // Four ties: requester 0 first every time (last grant was 1)
        tie(64'd1000, 64'd33, 64'd30, 64'd10, 64'd12345, 64'd100, 64'd123, 64'd45, "tie1_order");
        tie(64'd7, 64'd7, 64'd1, 64'd0, 64'd0, 64'd5, 64'd0, 64'd0, "tie2_order");
        tie(ONES, 64'd2, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1,
            64'h100_0000_0000, 64'h10_0000, 64'h10_0000, 64'd0, "tie3_order");
        tie(64'd999, 64'd1000, 64'd0, 64'd999, 64'd65536, 64'd255, 64'd257, 64'd1, "tie4_order");

        // Boundaries
        issue(1'b0, ONES, 64'd1, ONES, 64'd0, 1'b0);
        wait_idle();
        issue(1'b0, 64'd3, 64'd10, 64'd0, 64'd3, 1'b0);
        wait_idle();
        issue(1'b0, ONES, ONES, 64'd1, 64'd0, 1'b0);
        wait_idle();

        // req1 raised while requester 0 is in CALC
        fork
            issue(1'b0, 64'd50, 64'd6, 64'd8, 64'd2, 1'b0);
            begin
                repeat (15) @(posedge clk);
                #1 issue(1'b1, 64'd77, 64'd7, 64'd11, 64'd0, 1'b0);
            end
        join
        chk("ack1_first_idle", W'(ack_cyc[1] - ack_cyc[0]), W'(W + 2));
        wait_idle();

        // Reset in the middle of CALC: result discarded, no done afterwards
        issue(1'b0, 64'd1000, 64'd3, 64'd333, 64'd1, 1'b0);
        repeat (30) @(posedge clk);
        #3 rst = 1'b0;
        #1 void'(sb.pop_back());
        check_reset_outputs("midcalc_reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (80) @(posedge clk);
        #1 chk("no_busy_after_reset", W'(bus.busy), W'(0));

        // Priority pointer back at requester 0 after reset
        tie(64'd1000, 64'd3, 64'd333, 64'd1, 64'd81, 64'd9, 64'd9, 64'd0, "post_reset_tie_order");

        chk("scoreboard_empty", W'(sb.size()), W'(0));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/div_arbiter.md
DIV_ARBITER -- requirements
Module: div_arbiter

Interface
REQ-001 Parameter: WIDTH, 64, operand/result width in bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 req0, req1  input  1 each  requester N operands valid; held high until ackN.
REQ-005 a0, b0, a1, b1  input  WIDTH each  dividend/divisor of requester N, unsigned.
REQ-006 ack0, ack1  output  1 each  one-cycle pulse: requester N operands captured.
REQ-007 busy  output  1  high from operand capture until done is asserted.
REQ-008 done  output  1  one-cycle pulse: quot/rem valid.
REQ-009 done_id  output  1  owner of the current result (0 or 1).
REQ-010 quot, rem  output  WIDTH each  quotient and remainder, held until the next done.
REQ-011 dbz  output  1  divide-by-zero flag for the current result, held with quot/rem.

Function
REQ-012 The FSM SHALL have states IDLE, CALC and DONE.
- IDLE->CALC on any sampled req; IDLE->DONE on a req with divisor 0.
- CALC->DONE after WIDTH iterations; DONE->IDLE unconditionally.
REQ-013 On capture in IDLE, the block SHALL latch the operands and owner id, and SHALL pulse ackN for exactly the following cycle.
REQ-014 Arbitration SHALL be round-robin: if both requesters are asserted, grant goes to the requester not granted last; after reset, requester 0 wins the first tie.
REQ-015 Requests in CALC or DONE SHALL be ignored without ack, and SHALL be re-arbitrated on return to IDLE.
REQ-016 CALC SHALL run an unsigned restoring shift-subtract division, one quotient bit per cycle, MSB first, with a WIDTH+1-bit partial remainder.
REQ-017 Latency from the capture edge to done high SHALL be WIDTH+1 cycles for a nonzero divisor; back-to-back throughput is one result per WIDTH+2 cycles.
REQ-018 A zero divisor SHALL bypass CALC and give done one cycle after capture, with quot all-ones, rem equal to the dividend and dbz set; dbz is otherwise 0.
REQ-019 Results SHALL be exact for the full range, including dividend < divisor (quot 0, rem dividend) and all-ones / 1.
REQ-020 A requester dropping req before ack SHALL withdraw it; operand changes after ack SHALL have no effect.

Reset
REQ-021 With rst low, the block SHALL force state IDLE, the priority pointer to requester 0, and ack0/ack1/busy/done/done_id/dbz to 0 and quot/rem to 0, independent of clk.
REQ-022 A reset mid-CALC SHALL discard the in-flight operation; no done follows, and rst deassertion resumes normal arbitration on the next edge.

Structure
REQ-023 A shared package or header div_pkg SHALL hold the FSM state encodings and the WIDTH default; no other constants.
REQ-024 The iterative datapath (partial remainder, quotient shift register, iteration counter of width clog2(WIDTH)+1) SHALL be the sub-module seq_div_core, with start/dividend/divisor inputs and a finished output.
REQ-025 Arbitration, handshake and output registers SHALL stay in div_arbiter.

Verification (WIDTH=64)
REQ-026 Single request: req0, a0=100, b0=7 -> ack0 next cycle; done 65 cycles after capture; quot=14, rem=2, done_id=0, dbz=0.
REQ-027 Tie: req0 and req1 asserted together, repeated 4 times -> grants alternate 0,1,0,1; each result matches its own operands.
REQ-028 Zero divisor: req1, a1=5, b1=0 -> done 1 cycle after capture; quot=all-ones, rem=5, dbz=1, done_id=1.
REQ-029 Boundaries: all-ones/1 -> quot=all-ones, rem=0; 3/10 -> quot=0, rem=3; all-ones/all-ones -> quot=1, rem=0.
REQ-030 Reset at CALC iteration 30 -> all outputs immediately at reset values, no done pulse; the next request completes correctly.
REQ-031 req1 raised during CALC of requester 0 -> no ack1 until DONE->IDLE; requester 1 is captured on the first IDLE cycle.
